// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch datapath: instruction word, fetch FSM states,
// and the NOP encoding (BR with nzp=000) shown while no instruction is held.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DROP
  } lc3b_fetch_state;

  localparam lc3b_word lc3b_nop_word = 16'h0000;

endpackage

// File: rtl/fetch_slot.sv
// One instruction holding register {valid, ir, pc}; clear wins over load so a
// flush always empties the entry. A cleared entry shows the NOP word.
module fetch_slot
  import lc3b_types::*;
#(
  parameter lc3b_word NOP_WORD = lc3b_nop_word
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  logic     clear,
  input  lc3b_word ir_in,
  input  lc3b_word pc_in,
  output logic     valid,
  output lc3b_word ir,
  output lc3b_word pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      ir    <= NOP_WORD;
      pc    <= 16'h0000;
    end else if (clear) begin
      valid <= 1'b0;
      ir    <= NOP_WORD;
    end else if (load) begin
      valid <= 1'b1;
      ir    <= ir_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LC-3b IF stage: owns the fetch PC, talks to I-memory, buffers IR toward decode.
// Define FETCH_SKID_BUFFER_EN to add a one-entry skid so fetch continues during stalls.
module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word NOP_WORD = lc3b_nop_word
) (
  input  logic     clk,
  input  logic     reset_n,
  output logic     imem_read,
  output lc3b_word imem_address,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp,
  output lc3b_word ir_out,
  output lc3b_word pc_out,
  output lc3b_word pc_plus2_out,
  output logic     ir_valid,
  input  logic     decode_ready,
  input  logic     redirect,
  input  lc3b_word redirect_pc
);

  lc3b_fetch_state state, state_next;
  lc3b_word        req_pc, req_pc_next;
  lc3b_word        next_pc, next_pc_next;
  lc3b_word        target;
  logic            transfer;

  logic            out_load, out_clear, out_valid;
  lc3b_word        out_ir_in, out_pc_in, out_ir, out_pc;

`ifdef FETCH_SKID_BUFFER_EN
  logic            skid_load, skid_clear, skid_valid;
  lc3b_word        skid_ir, skid_pc;
`endif

  assign target       = redirect_pc & 16'hFFFE;
  assign transfer     = out_valid & decode_ready;
  // Gated by reset_n so the request drops the instant reset asserts.
  assign imem_read    = reset_n & (state != S_HOLD);
  assign imem_address = req_pc;
  assign ir_out       = out_ir;
  assign pc_out       = out_pc;
  assign pc_plus2_out = out_pc + 16'd2;
  assign ir_valid     = out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      req_pc  <= RESET_PC;
      next_pc <= RESET_PC;
    end else begin
      state   <= state_next;
      req_pc  <= req_pc_next;
      next_pc <= next_pc_next;
    end
  end

  always_comb begin
    state_next   = state;
    req_pc_next  = req_pc;
    next_pc_next = next_pc;
    out_load     = 1'b0;
    out_ir_in    = imem_rdata;
    out_pc_in    = req_pc;
`ifdef FETCH_SKID_BUFFER_EN
    skid_load    = 1'b0;
    skid_clear   = redirect;
`endif
    if (redirect) begin
      // A pending request must finish before req_pc may move, hence S_DROP.
      if (state != S_HOLD && !imem_resp) begin
        state_next   = S_DROP;
        next_pc_next = target;
      end else begin
        state_next  = S_FETCH;
        req_pc_next = target;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_resp) begin
            if (!out_valid || decode_ready) begin
              out_load    = 1'b1;
              req_pc_next = req_pc + 16'd2;
`ifdef FETCH_SKID_BUFFER_EN
              state_next  = S_FETCH;
`else
              state_next  = S_HOLD;
`endif
            end else begin
`ifdef FETCH_SKID_BUFFER_EN
              skid_load   = 1'b1;
              req_pc_next = req_pc + 16'd2;
              state_next  = S_HOLD;
`endif
            end
          end
        end
        S_HOLD: begin
          if (transfer) begin
            state_next = S_FETCH;
`ifdef FETCH_SKID_BUFFER_EN
            if (skid_valid) begin
              out_load   = 1'b1;
              out_ir_in  = skid_ir;
              out_pc_in  = skid_pc;
              skid_clear = 1'b1;
            end
`endif
          end
        end
        S_DROP: begin
          if (imem_resp) begin
            state_next  = S_FETCH;
            req_pc_next = next_pc;
          end
        end
        default: state_next = S_FETCH;
      endcase
    end
    out_clear = redirect | (transfer & ~out_load);
  end

  fetch_slot #(.NOP_WORD(NOP_WORD)) u_out_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (out_load),
    .clear   (out_clear),
    .ir_in   (out_ir_in),
    .pc_in   (out_pc_in),
    .valid   (out_valid),
    .ir      (out_ir),
    .pc      (out_pc)
  );

`ifdef FETCH_SKID_BUFFER_EN
  fetch_slot #(.NOP_WORD(NOP_WORD)) u_skid_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .ir_in   (imem_rdata),
    .pc_in   (req_pc),
    .valid   (skid_valid),
    .ir      (skid_ir),
    .pc      (skid_pc)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, stall, redirects, PC wrap and async reset.
// Expectations follow the default build; the stall sequence also covers FETCH_SKID_BUFFER_EN.
module tb_fetch_unit;

`ifdef FETCH_SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2_out;
  logic        ir_valid;
  logic        decode_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .ir_out       (ir_out),
    .pc_out       (pc_out),
    .pc_plus2_out (pc_plus2_out),
    .ir_valid     (ir_valid),
    .decode_ready (decode_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance to the next sampling point (negedge).
  task automatic applyStimulus(input logic resp, input logic [15:0] rdata, input logic ready,
                               input logic redir, input logic [15:0] rpc);
    imem_resp    = resp;
    imem_rdata   = rdata;
    decode_ready = ready;
    redirect     = redir;
    redirect_pc  = rpc;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; imem_resp = 1'b0; imem_rdata = 16'h0; decode_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_read",   imem_read,    16'd0);
    checkOutput("rst_valid",  ir_valid,     16'd0);
    checkOutput("rst_ir",     ir_out,       16'h0000);
    checkOutput("rst_pc",     pc_out,       16'h0000);
    checkOutput("rst_pc2",    pc_plus2_out, 16'h0002);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] test 1: idle after reset");
    checkOutput("t1_read",  imem_read,    16'd1);
    checkOutput("t1_addr",  imem_address, 16'h0000);
    checkOutput("t1_valid", ir_valid,     16'd0);
    checkOutput("t1_ir",    ir_out,       16'h0000);

    $display("[TB] test 2: first fetch");
    applyStimulus(1'b1, 16'h1021, 1'b1, 1'b0, 16'h0);
    checkOutput("t2_ir",    ir_out,       16'h1021);
    checkOutput("t2_pc",    pc_out,       16'h0000);
    checkOutput("t2_pc2",   pc_plus2_out, 16'h0002);
    checkOutput("t2_valid", ir_valid,     16'd1);
    checkOutput("t2_addr",  imem_address, 16'h0002);
    checkOutput("t2_read",  imem_read,    SKID ? 16'd1 : 16'd0);

    $display("[TB] test 3: decode stall");
    if (SKID) begin
      applyStimulus(1'b1, 16'h5062, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 5; i++) begin
        checkOutput("t3_stall_read", imem_read, 16'd0);
        checkOutput("t3_stall_ir",   ir_out,    16'h1021);
        applyStimulus(1'b0, 16'h0, (i == 4), 1'b0, 16'h0);
      end
      checkOutput("t3_skid_ir",    ir_out,       16'h5062);
      checkOutput("t3_skid_pc",    pc_out,       16'h0002);
      checkOutput("t3_skid_valid", ir_valid,     16'd1);
      checkOutput("t3_skid_addr",  imem_address, 16'h0004);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        checkOutput("t3_stall_read",  imem_read, 16'd0);
        checkOutput("t3_stall_ir",    ir_out,    16'h1021);
        checkOutput("t3_stall_valid", ir_valid,  16'd1);
      end
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("t3_rel_valid", ir_valid,     16'd0);
      checkOutput("t3_rel_ir",    ir_out,       16'h0000);
      checkOutput("t3_rel_addr",  imem_address, 16'h0002);
      checkOutput("t3_rel_read",  imem_read,    16'd1);
      applyStimulus(1'b1, 16'h5062, 1'b1, 1'b0, 16'h0);
      checkOutput("t3_second_ir",  ir_out,       16'h5062);
      checkOutput("t3_second_pc",  pc_out,       16'h0002);
      checkOutput("t3_second_pc2", pc_plus2_out, 16'h0004);
      checkOutput("t3_second_read", imem_read,   16'd0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    end
    checkOutput("t3_end_valid", ir_valid,     16'd0);
    checkOutput("t3_end_addr",  imem_address, 16'h0004);
    checkOutput("t3_end_read",  imem_read,    16'd1);

    $display("[TB] test 4: redirect while request pending");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h3001);
    checkOutput("t4_drop_addr",  imem_address, 16'h0004);
    checkOutput("t4_drop_read",  imem_read,    16'd1);
    checkOutput("t4_drop_valid", ir_valid,     16'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("t4_wait_addr", imem_address, 16'h0004);
      checkOutput("t4_wait_read", imem_read,    16'd1);
    end
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0);
    checkOutput("t4_new_addr",  imem_address, 16'h3000);
    checkOutput("t4_new_read",  imem_read,    16'd1);
    checkOutput("t4_new_valid", ir_valid,     16'd0);
    checkOutput("t4_new_ir",    ir_out,       16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("t4_after_valid", ir_valid,     16'd0);
    checkOutput("t4_after_addr",  imem_address, 16'h3000);

    $display("[TB] test 5: redirect coincident with response, PC wrap");
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b1, 16'hFFFF);
    checkOutput("t5_valid", ir_valid,     16'd0);
    checkOutput("t5_ir",    ir_out,       16'h0000);
    checkOutput("t5_addr",  imem_address, 16'hFFFE);
    checkOutput("t5_read",  imem_read,    16'd1);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0);
    checkOutput("t5_wrap_ir",   ir_out,       16'h1234);
    checkOutput("t5_wrap_pc",   pc_out,       16'hFFFE);
    checkOutput("t5_wrap_pc2",  pc_plus2_out, 16'h0000);
    checkOutput("t5_wrap_addr", imem_address, 16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("t5_z_valid", ir_valid,     16'd0);
    checkOutput("t5_z_addr",  imem_address, 16'h0000);
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0);
    checkOutput("t5_z_ir",    ir_out,       16'h5555);
    checkOutput("t5_z_pc",    pc_out,       16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    checkOutput("t5_two_addr", imem_address, 16'h0002);
    checkOutput("t5_two_read", imem_read,    16'd1);

    $display("[TB] test 6: asynchronous reset mid-request");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_read",  imem_read,    16'd0);
    checkOutput("t6_valid", ir_valid,     16'd0);
    checkOutput("t6_addr",  imem_address, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_rel_read", imem_read,    16'd1);
    checkOutput("t6_rel_addr", imem_address, 16'h0000);
    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0);
    checkOutput("t6_ir",    ir_out,       16'h7777);
    checkOutput("t6_pc",    pc_out,       16'h0000);
    checkOutput("t6_next",  imem_address, 16'h0002);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
